// File: rtl/odo_sbox_small_seq_pkg.sv
// Shared definitions for the Odo small S-box sequencer.
//   ODO_SBOX_SMALL_W : width of one small S-box chunk (address and data).
//   odo_seq_state_e  : sequencer FSM states.
//   odo_cnt_width()  : bits needed for a chunk counter that reaches nchunk.
package odo_sbox_small_seq_pkg;

  localparam int unsigned ODO_SBOX_SMALL_W = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } odo_seq_state_e;

  // Counter must hold 0..nchunk inclusive (the extra value is the drain cycle).
  function automatic int unsigned odo_cnt_width(input int unsigned nchunk);
    return $clog2(nchunk + 1);
  endfunction

endpackage

// File: rtl/odo_sbox_small_seq.sv
// Odo small S-box sequencer: streams a wide state word through one shared,
// registered 6-bit S-box, one chunk per cycle, and reassembles the result.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   input word offered
//   in_ready_o   word accepted on this edge (combinational: state, out_ready_i, flush_i)
//   in_data_i    source word, chunk k = bits [6k+5:6k]
//   out_valid_o  substituted word available (registered)
//   out_ready_i  consumer takes the word
//   out_data_o   substituted word, chunk k = S(in chunk k)
//   flush_i      synchronous abort of the word in flight
//   busy_o       high in RUN or DONE (registered)
//   sbox_in_o    S-box address (from registers only)
//   sbox_out_i   S-box data, valid one cycle after its address
module odo_sbox_small_seq
  import odo_sbox_small_seq_pkg::*;
#(
  parameter int unsigned NChunk = 10
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [ODO_SBOX_SMALL_W*NChunk-1:0]   in_data_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [ODO_SBOX_SMALL_W*NChunk-1:0]   out_data_o,
  input  logic                                 flush_i,
  output logic                                 busy_o,
  output logic [ODO_SBOX_SMALL_W-1:0]          sbox_in_o,
  input  logic [ODO_SBOX_SMALL_W-1:0]          sbox_out_i
);

  localparam int unsigned SW   = ODO_SBOX_SMALL_W;
  localparam int unsigned CntW = odo_cnt_width(NChunk);
  localparam logic [CntW-1:0] CntLast = CntW'(NChunk);

  odo_seq_state_e state_q;

  logic [NChunk-1:0][SW-1:0] src_q;
  logic [NChunk-1:0][SW-1:0] dst_q, dst_d;
  logic [CntW-1:0]           cnt_q;
  logic                      out_valid_q;
  logic                      busy_q;
  logic [SW-1:0]             sbox_sel;

  // Chunk selection is a compare-per-chunk mux so the counter's drain value
  // (cnt == NChunk) never forms an out-of-range index.
  always_comb begin
    sbox_sel = '0;
    dst_d    = dst_q;
    if (state_q == StRun) begin
      for (int unsigned k = 0; k < NChunk; k++) begin
        // Issue: address for chunk cnt goes out this cycle.
        if (cnt_q == CntW'(k)) begin
          sbox_sel = src_q[k];
        end
        // Capture: data for the address issued last cycle arrives now.
        if (cnt_q == CntW'(k + 1)) begin
          dst_d[k] = sbox_out_i;
        end
      end
    end
  end

  assign in_ready_o  = ~flush_i &
                       ((state_q == StIdle) | ((state_q == StDone) & out_ready_i));
  assign out_valid_o = out_valid_q;
  assign out_data_o  = dst_q;
  assign busy_o      = busy_q;
  assign sbox_in_o   = sbox_sel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush_i) begin
      // dst is intentionally left as-is; only the handshake state is dropped.
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            src_q   <= in_data_i;
            cnt_q   <= '0;
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          dst_q <= dst_d;
          if (cnt_q == CntLast) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            if (in_valid_i) begin
              // Back-to-back: next word is accepted on the consume edge.
              src_q   <= in_data_i;
              cnt_q   <= '0;
              state_q <= StRun;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_odo_sbox_small_seq.sv
// Self-checking bench for odo_sbox_small_seq: random and directed words are
// compared against a chunk-wise table lookup of the input word.
module tb_odo_sbox_small_seq;

  localparam int unsigned N = 10;
  localparam int unsigned W = 6 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         flush = 1'b0;
  logic         busy;
  logic [5:0]   sbox_in;
  logic [5:0]   sbox_out = '0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  odo_sbox_small_seq #(.NChunk(N)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .flush_i     (flush),
    .busy_o      (busy),
    .sbox_in_o   (sbox_in),
    .sbox_out_i  (sbox_out)
  );

  // Small S-box table; entries not listed follow an odd-multiplier bijection.
  function automatic logic [5:0] sbox_tab(input logic [5:0] x);
    logic [5:0] t;
    case (x)
      6'd0:  t = 6'h26;
      6'd1:  t = 6'h3d;
      6'd2:  t = 6'h1e;
      6'd3:  t = 6'h3c;
      6'd4:  t = 6'h12;
      6'd5:  t = 6'h2a;
      6'd6:  t = 6'h33;
      6'd7:  t = 6'h0a;
      6'd8:  t = 6'h25;
      6'd9:  t = 6'h2d;
      6'd63: t = 6'h0e;
      default: t = x * 6'd29 + 6'd7;
    endcase
    return t;
  endfunction

  // Registered S-box: address in cycle t, data in cycle t+1.
  always @(posedge clk) sbox_out <= sbox_tab(sbox_in);

  function automatic logic [W-1:0] ref_word(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int k = 0; k < int'(N); k++) r[6*k +: 6] = sbox_tab(w[6*k +: 6]);
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  // Offer one word from IDLE, check latency and result, then consume it.
  task automatic run_word(input string tag, input logic [W-1:0] w);
    int lat;
    in_data  = w;
    in_valid = 1'b1;
    #1;
    check_eq({tag, " in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check_eq({tag, " busy"}, 64'(busy), 64'd1);
    wait_out(lat);
    check_eq({tag, " latency"}, 64'(lat), 64'(N + 1));
    check_eq({tag, " data"}, 64'(out_data), 64'(ref_word(w)));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, " consumed"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] ramp;
    logic [W-1:0] ones;
    logic [W-1:0] bw [4];
    logic [W-1:0] held;
    int lat;
    int hits;
    int bad;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset out_valid", 64'(out_valid), 64'd0);
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset sbox_in", 64'(sbox_in), 64'd0);
    check_eq("reset out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("idle in_ready", 64'(in_ready), 64'd1);

    // Directed words.
    run_word("zero", '0);
    check_eq("zero chunk0", 64'(out_data[5:0]), 64'h26);
    for (int k = 0; k < int'(N); k++) ramp[6*k +: 6] = 6'(k);
    run_word("ramp", ramp);
    ones = '1;
    run_word("ones", ones);

    // Random words.
    for (int i = 0; i < 6; i++) begin
      w = W'({$urandom(), $urandom()});
      run_word("rand", w);
    end

    // Back-to-back with out_ready and in_valid held high.
    for (int i = 0; i < 4; i++) bw[i] = W'({$urandom(), $urandom()});
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = bw[0];
    tick();
    for (int i = 0; i < 4; i++) begin
      wait_out(lat);
      check_eq("b2b latency", 64'(lat), 64'(N + 1));
      check_eq("b2b data", 64'(out_data), 64'(ref_word(bw[i])));
      if (i < 3) begin
        in_data = bw[i + 1];
        #1;
        check_eq("b2b in_ready", 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    out_ready = 1'b0;
    check_eq("b2b idle busy", 64'(busy), 64'd0);
    check_eq("b2b idle out_valid", 64'(out_valid), 64'd0);

    // Backpressure: hold the result for 20 cycles while a new word is offered.
    held     = W'({$urandom(), $urandom()});
    in_data  = held;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    check_eq("bp latency", 64'(lat), 64'(N + 1));
    in_valid = 1'b1;
    in_data  = ~held;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (out_data !== ref_word(held) || in_ready !== 1'b0 || sbox_in !== 6'h00 ||
          out_valid !== 1'b1) bad++;
      tick();
    end
    check_eq("bp hold violations", 64'(bad), 64'd0);
    check_eq("bp data", 64'(out_data), 64'(ref_word(held)));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp released", 64'(out_valid), 64'd0);
    check_eq("bp idle", 64'(busy), 64'd0);

    // Flush at cnt = 4.
    in_data  = W'({$urandom(), $urandom()});
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    flush    = 1'b1;
    in_valid = 1'b1;
    #1;
    check_eq("flush in_ready", 64'(in_ready), 64'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush busy", 64'(busy), 64'd0);
    check_eq("flush sbox_in", 64'(sbox_in), 64'd0);
    hits = 0;
    for (int c = 0; c < 15; c++) begin
      if (out_valid) hits++;
      tick();
    end
    check_eq("flush no out_valid", 64'(hits), 64'd0);
    run_word("post-flush ones", ones);

    // Asynchronous reset mid-RUN.
    in_data  = W'({$urandom(), $urandom()});
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async rst busy", 64'(busy), 64'd0);
    check_eq("async rst out_valid", 64'(out_valid), 64'd0);
    check_eq("async rst sbox_in", 64'(sbox_in), 64'd0);
    check_eq("async rst out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("post rst in_ready", 64'(in_ready), 64'd1);
    check_eq("post rst busy", 64'(busy), 64'd0);
    w = W'({$urandom(), $urandom()});
    run_word("post rst", w);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
